// File: rtl/uart_pkg.sv
// Shared UART constants and baud-controller FSM encoding, common to the TX, RX and baud blocks.
package uart_pkg;

  localparam int unsigned DVSR_MIN     = 2;
  localparam int unsigned DVSR_RST_DEF = 163;  // 50 MHz / (16 * 19200)
  localparam int unsigned OSR_DEF      = 16;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } baud_state_e;

endpackage

// File: rtl/uart_baud_ctrl_if.sv
// Divisor configuration handshake between the configuration side and the baud controller.
interface uart_baud_ctrl_if #(
  parameter int unsigned N = 8
) ();

  logic         cfg_valid;
  logic [N-1:0] cfg_divisor;
  logic         cfg_ready;
  logic         cfg_err;

  modport master (output cfg_valid, output cfg_divisor, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_divisor, output cfg_ready, output cfg_err);

endinterface

// File: rtl/uart_tick_div.sv
// Loadable modulo-D counter producing the one-cycle oversampling tick.
module uart_tick_div #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] divisor,
  output logic         s_tick
);

  logic [N-1:0] cnt;
  logic [N-1:0] last;

  assign last   = divisor - N'(1);
  assign s_tick = en && (cnt == last);

  // Clear wins over the increment so a divisor change always restarts the period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || clr || (cnt == last)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + N'(1);
    end
  end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud-rate controller: owns the divisor, defers updates until the UART is idle, emits s_tick/b_tick.
module uart_baud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned DVSR_RST = DVSR_RST_DEF,
  parameter int unsigned OSR      = OSR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             uart_busy,
  uart_baud_ctrl_if.slave  cfg,
  output logic             s_tick,
  output logic             b_tick,
  output logic [N-1:0]     cur_divisor
);

  localparam int unsigned OSW = $clog2(OSR);

  baud_state_e    state;
  logic [N-1:0]   shadow;
  logic [OSW-1:0] os_cnt;
  logic           accept;
  logic           apply;

  assign cfg.cfg_ready = (state == ST_RUN);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign apply         = (state == ST_PEND) && !uart_busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RUN;
      shadow      <= N'(DVSR_RST);
      cur_divisor <= N'(DVSR_RST);
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (accept) begin
            if (cfg.cfg_divisor < N'(DVSR_MIN)) begin
              cfg.cfg_err <= 1'b1;
            end else begin
              shadow <= cfg.cfg_divisor;
              state  <= ST_PEND;
            end
          end
        end
        ST_PEND: begin
          if (apply) begin
            cur_divisor <= shadow;
            state       <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  uart_tick_div #(
    .N (N)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (apply),
    .divisor (cur_divisor),
    .s_tick  (s_tick)
  );

  // OSR is a power of two, so the natural wrap of os_cnt is the modulo-OSR count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      os_cnt <= '0;
    end else if (!en || apply) begin
      os_cnt <= '0;
    end else if (s_tick) begin
      os_cnt <= os_cnt + OSW'(1);
    end
  end

  assign b_tick = s_tick && (os_cnt == OSW'(OSR - 1));

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl: reset, idle/deferred updates, invalid divisors, gating, reset in PEND.
module tb_uart_baud_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic       uart_busy;
  logic       s_tick;
  logic       b_tick;
  logic [7:0] cur_divisor;

  int n_cmp;
  int n_bad;
  int err_pulses;
  int orphan_btick;

  uart_baud_ctrl_if #(.N(8)) cfg ();

  uart_baud_ctrl #(
    .N        (8),
    .DVSR_RST (163),
    .OSR      (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .uart_busy   (uart_busy),
    .cfg         (cfg),
    .s_tick      (s_tick),
    .b_tick      (b_tick),
    .cur_divisor (cur_divisor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && b_tick && !s_tick) orphan_btick++;
    if (cfg.cfg_err) err_pulses++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_stick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tick && n < 5000);
  endtask

  task automatic wait_btick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_tick && n < 10000);
  endtask

  task automatic write_div(input logic [7:0] d);
    cfg.cfg_valid   = 1'b1;
    cfg.cfg_divisor = d;
    step(1);
    cfg.cfg_valid   = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    int n;
    int e0;
    reset = 1'b0; en = 1'b0; uart_busy = 1'b0;
    cfg.cfg_valid = 1'b0; cfg.cfg_divisor = '0;
    step(3);
    n_cmp++; if (cur_divisor !== 8'd163) begin n_bad++; $display("FAIL reset_cur_divisor: got %0d want 163", cur_divisor); end
    n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready: got %b want 1", cfg.cfg_ready); end
    n_cmp++; if (cfg.cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_err: got %b want 0", cfg.cfg_err); end
    n_cmp++; if (s_tick !== 1'b0 || b_tick !== 1'b0) begin n_bad++; $display("FAIL reset_ticks: got s=%b b=%b want 0 0", s_tick, b_tick); end
    e0 = err_pulses;
    reset = 1'b1; en = 1'b1;
    wait_stick(n);
    n_cmp++; if (n !== 162) begin n_bad++; $display("FAIL reset_first_stick: got %0d cycles want 162", n); end
    n_cmp++; if (b_tick !== 1'b0) begin n_bad++; $display("FAIL reset_first_btick_early: got %b want 0", b_tick); end
    wait_stick(n);
    n_cmp++; if (n !== 163) begin n_bad++; $display("FAIL reset_stick_period: got %0d want 163", n); end
    wait_btick(n);
    n_cmp++; if (n !== 2282) begin n_bad++; $display("FAIL reset_first_btick: got %0d want 2282", n); end
    wait_btick(n);
    n_cmp++; if (n !== 2608) begin n_bad++; $display("FAIL reset_btick_period: got %0d want 2608", n); end
    n_cmp++; if (err_pulses !== e0) begin n_bad++; $display("FAIL reset_no_err: got %0d pulses want 0", err_pulses - e0); end
  endtask

  task automatic test_idle_update();
    int n;
    uart_busy = 1'b0;
    cfg.cfg_valid = 1'b1; cfg.cfg_divisor = 8'd10;
    n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready_T: got %b want 1", cfg.cfg_ready); end
    step(1);
    cfg.cfg_valid = 1'b0;
    n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready_T1: got %b want 0", cfg.cfg_ready); end
    n_cmp++; if (cur_divisor !== 8'd163) begin n_bad++; $display("FAIL idle_cur_T1: got %0d want 163", cur_divisor); end
    step(1);
    n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready_T2: got %b want 1", cfg.cfg_ready); end
    n_cmp++; if (cur_divisor !== 8'd10) begin n_bad++; $display("FAIL idle_cur_T2: got %0d want 10", cur_divisor); end
    n_cmp++; if (dut.u_div.cnt !== 8'd0) begin n_bad++; $display("FAIL idle_cnt_T2: got %0d want 0", dut.u_div.cnt); end
    wait_stick(n);
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL idle_first_stick: got %0d want 9", n); end
    wait_btick(n);
    n_cmp++; if (n !== 150) begin n_bad++; $display("FAIL idle_first_btick: got %0d want 150", n); end
    wait_btick(n);
    n_cmp++; if (n !== 160) begin n_bad++; $display("FAIL idle_btick_period: got %0d want 160", n); end
  endtask

  task automatic test_deferred_update();
    int n;
    uart_busy = 1'b1;
    cfg.cfg_valid = 1'b1; cfg.cfg_divisor = 8'd20;
    step(1);
    cfg.cfg_divisor = 8'd30;
    n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL defer_ready_pend: got %b want 0", cfg.cfg_ready); end
    wait_stick(n);
    wait_stick(n);
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL defer_old_rate: got %0d want 10", n); end
    n_cmp++; if (cfg.cfg_ready !== 1'b0 || cur_divisor !== 8'd10) begin n_bad++; $display("FAIL defer_held: got ready=%b cur=%0d want 0 10", cfg.cfg_ready, cur_divisor); end
    cfg.cfg_valid = 1'b0;
    step(1);
    uart_busy = 1'b0;
    step(1);
    n_cmp++; if (cur_divisor !== 8'd20) begin n_bad++; $display("FAIL defer_apply_cur: got %0d want 20", cur_divisor); end
    n_cmp++; if (dut.u_div.cnt !== 8'd0 || dut.os_cnt !== 4'd0) begin n_bad++; $display("FAIL defer_apply_clear: got cnt=%0d os=%0d want 0 0", dut.u_div.cnt, dut.os_cnt); end
    n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL defer_apply_ready: got %b want 1", cfg.cfg_ready); end
    wait_stick(n);
    n_cmp++; if (n !== 19) begin n_bad++; $display("FAIL defer_new_first_stick: got %0d want 19", n); end
  endtask

  task automatic test_invalid_divisor();
    int e0;
    e0 = err_pulses;
    uart_busy = 1'b0;
    cfg.cfg_valid = 1'b1; cfg.cfg_divisor = 8'd0;
    step(1);
    cfg.cfg_divisor = 8'd1;
    n_cmp++; if (cfg.cfg_err !== 1'b1) begin n_bad++; $display("FAIL invalid0_err: got %b want 1", cfg.cfg_err); end
    n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL invalid0_no_pend: got ready=%b want 1", cfg.cfg_ready); end
    step(1);
    cfg.cfg_valid = 1'b0;
    n_cmp++; if (cfg.cfg_err !== 1'b1 || cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL invalid1_err: got err=%b ready=%b want 1 1", cfg.cfg_err, cfg.cfg_ready); end
    step(1);
    n_cmp++; if (cfg.cfg_err !== 1'b0) begin n_bad++; $display("FAIL invalid_err_width: got %b want 0", cfg.cfg_err); end
    n_cmp++; if (cur_divisor !== 8'd20) begin n_bad++; $display("FAIL invalid_cur_kept: got %0d want 20", cur_divisor); end
    step(1);
    n_cmp++; if (err_pulses - e0 !== 2) begin n_bad++; $display("FAIL invalid_pulse_count: got %0d want 2", err_pulses - e0); end
  endtask

  task automatic test_divisor_bounds();
    int n;
    write_div(8'd2);
    n_cmp++; if (cur_divisor !== 8'd2) begin n_bad++; $display("FAIL min_cur: got %0d want 2", cur_divisor); end
    wait_stick(n);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL min_first_stick: got %0d want 1", n); end
    wait_stick(n);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL min_stick_period: got %0d want 2", n); end
    wait_btick(n);
    n_cmp++; if (n !== 28) begin n_bad++; $display("FAIL min_first_btick: got %0d want 28", n); end
    wait_btick(n);
    n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL min_btick_period: got %0d want 32", n); end
    write_div(8'd255);
    wait_stick(n);
    n_cmp++; if (n !== 254) begin n_bad++; $display("FAIL max_first_stick: got %0d want 254", n); end
    wait_stick(n);
    n_cmp++; if (n !== 255) begin n_bad++; $display("FAIL max_stick_period: got %0d want 255", n); end
  endtask

  task automatic test_enable_gating();
    int n;
    int ticks;
    write_div(8'd10);
    step(25);
    n_cmp++; if (dut.u_div.cnt !== 8'd5 || dut.os_cnt !== 4'd2) begin n_bad++; $display("FAIL gate_pre: got cnt=%0d os=%0d want 5 2", dut.u_div.cnt, dut.os_cnt); end
    en = 1'b0;
    step(1);
    n_cmp++; if (dut.u_div.cnt !== 8'd0 || dut.os_cnt !== 4'd0) begin n_bad++; $display("FAIL gate_cleared: got cnt=%0d os=%0d want 0 0", dut.u_div.cnt, dut.os_cnt); end
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      if (s_tick || b_tick) ticks++;
      step(1);
    end
    n_cmp++; if (ticks !== 0) begin n_bad++; $display("FAIL gate_no_ticks: got %0d want 0", ticks); end
    write_div(8'd12);
    n_cmp++; if (cur_divisor !== 8'd12) begin n_bad++; $display("FAIL gate_cfg_while_off: got %0d want 12", cur_divisor); end
    en = 1'b1;
    wait_stick(n);
    n_cmp++; if (n !== 11) begin n_bad++; $display("FAIL gate_first_stick: got %0d want 11", n); end
  endtask

  task automatic test_reset_in_pend();
    uart_busy = 1'b1;
    cfg.cfg_valid = 1'b1; cfg.cfg_divisor = 8'd50;
    step(1);
    cfg.cfg_valid = 1'b0;
    n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rpend_entered: got ready=%b want 0", cfg.cfg_ready); end
    step(2);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    n_cmp++; if (cur_divisor !== 8'd163 || cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rpend_after_reset: got cur=%0d ready=%b want 163 1", cur_divisor, cfg.cfg_ready); end
    step(2);
    uart_busy = 1'b0;
    step(3);
    n_cmp++; if (cur_divisor !== 8'd163 || cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rpend_discarded: got cur=%0d ready=%b want 163 1", cur_divisor, cfg.cfg_ready); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; err_pulses = 0; orphan_btick = 0;
    test_reset();
    test_idle_update();
    test_deferred_update();
    test_invalid_divisor();
    test_divisor_bounds();
    test_enable_gating();
    test_reset_in_pend();
    n_cmp++; if (orphan_btick !== 0) begin n_bad++; $display("FAIL btick_alignment: got %0d orphan b_ticks want 0", orphan_btick); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Programmable baud-rate controller for the UART IP core. Owns the baud divisor, generates the 16x oversampling tick (`s_tick`) and the bit-rate tick (`b_tick`) consumed by the transmitter and receiver. Accepts divisor updates from the configuration side through a valid/ready handshake. Defers each update until the UART is idle, so a frame in flight never changes rate mid-bit.

## Interface
- `N`, 8: divisor and counter width.
- `DVSR_RST`, 163: divisor loaded at reset (50 MHz / (16 × 19200)); must be ≥ 2.
- `OSR`, 16: `s_tick` per `b_tick`; power of two, ≥ 2.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  tick generation enable.
- `uart_busy`  in  1  TX or RX frame in progress.
- `cfg_valid`  in  1  new divisor offered.
- `cfg_divisor`  in  N  offered divisor value.
- `cfg_ready`  out  1  controller can accept a divisor.
- `cfg_err`  out  1  one-cycle pulse: an offered divisor was rejected.
- `s_tick`  out  1  one-cycle oversampling tick.
- `b_tick`  out  1  one-cycle bit tick, coincident with every OSR-th `s_tick`.
- `cur_divisor`  out  N  divisor currently in use.

## Operation
- **Tick counter** `cnt`: counts 0..D−1, where D = `cur_divisor`.
  - `s_tick` = `en` && `cnt` == D−1. It is decoded from registered state.
  - At D−1, `cnt` wraps to 0. The `s_tick` period is exactly D cycles.
- **Oversample counter** `os_cnt`: counts 0..OSR−1, incrementing on each `s_tick`.
  - `b_tick` = `s_tick` && `os_cnt` == OSR−1.
- **`en` = 0**:
  - `cnt` and `os_cnt` are forced to 0.
  - No ticks are emitted.
  - The configuration handshake still operates.
- **FSM states**: RUN and PEND.
- **RUN**:
  - `cfg_ready` = 1.
  - On `cfg_valid` && `cfg_ready`:
    - If `cfg_divisor` < 2: assert `cfg_err` for one cycle (the next cycle), stay in RUN, leave `cur_divisor` unchanged.
    - Otherwise: capture the value into the shadow register and go to PEND.
- **PEND**:
  - `cfg_ready` = 0. Ticks continue at the old divisor.
  - In any PEND cycle with `uart_busy` = 0, the clock edge ending that cycle:
    - loads `cur_divisor` from the shadow register,
    - clears `cnt` and `os_cnt` (this overrides the normal increment or wrap),
    - returns the FSM to RUN.
  - A tick decoded in that same cycle is still emitted.
- `cfg_valid` while `cfg_ready` = 0 has no effect. The requester holds `cfg_valid` until it is accepted.
- Writing the same value as `cur_divisor` is a full update: the counters are cleared on apply.

## Timing
- **Reset** (`reset` = 0 at a clock edge) sets:
  - `cur_divisor` = `DVSR_RST`, `cnt` = 0, `os_cnt` = 0, state = RUN, shadow register = `DVSR_RST`.
- **Outputs after the reset edge**: `cfg_ready` = 1, `cfg_err` = 0, `s_tick` = 0, `b_tick` = 0.
- **Reset during PEND**: the captured divisor is discarded. `DVSR_RST` is restored.
- **First ticks**: with `en` = 1 from the reset release, the first `s_tick` occurs D−1 cycles after the first non-reset edge. The first `b_tick` is on the OSR-th `s_tick`.
- **Update latency**: handshake accepted in cycle T.
  - PEND in T+1.
  - If `uart_busy` = 0 in T+1, then in T+2: new `cur_divisor`, `cnt` = 0, `cfg_ready` = 1.
  - Best-case acceptance-to-apply is 2 cycles. Otherwise it is unbounded, until `uart_busy` falls.
- **`cfg_err` latency**: asserted in T+1 for exactly one cycle.
- **`b_tick` alignment**: `b_tick` never asserts without `s_tick` in the same cycle.
- **Minimum divisor** D = 2: `s_tick` every other cycle.
- **Arithmetic**: all counters are N bits wide (`os_cnt` is log2(OSR) bits) and never overflow. The legal divisor range is 2..2^N−1.

## Structure
- **Shared package `uart_pkg`**:
  - FSM state enum (RUN, PEND).
  - `DVSR_MIN` = 2.
  - Default `DVSR_RST` and `OSR` constants, shared with the TX and RX blocks.
- **Sub-module `uart_tick_div`**: loadable modulo-D counter with enable and synchronous clear, producing `s_tick`.
- **Top level `uart_baud_ctrl`** holds:
  - the FSM,
  - the shadow and `cur_divisor` registers,
  - `os_cnt` and the `b_tick` decode.

## Test plan
- **Reset defaults**: reset held 3 cycles, then `en` = 1 with `DVSR_RST` = 163 → `cur_divisor` = 163, `cfg_ready` = 1, `s_tick` period 163 cycles, `b_tick` every 2608 cycles, `cfg_err` never asserted.
- **Idle update**: `uart_busy` = 0, write `cfg_divisor` = 10 → `cfg_ready` low for exactly 1 cycle, `cur_divisor` = 10 two cycles after acceptance, then `s_tick` every 10 cycles and `b_tick` every 160.
- **Deferred update**: `uart_busy` = 1, write 20 → old rate continues and `cfg_ready` stays 0. A second `cfg_valid` with 30 is ignored. Drop `uart_busy` → `cur_divisor` = 20 on the next edge, counters cleared.
- **Invalid divisors**: write 0, then 1 → a one-cycle `cfg_err` for each, `cur_divisor` unchanged, no PEND entry.
- **Enable gating**: `en` low mid-count at `cnt` = 5 → no ticks, counters read 0. `en` high → the first `s_tick` follows D−1 cycles later.
- **Reset during PEND**: `uart_busy` = 1, write 50, assert reset → `cur_divisor` = 163 and state RUN after reset. Releasing `uart_busy` later does not apply 50.
